// File: rtl/key_edge_pio_pkg.sv
// Shared register map and edge-type encodings for the board PIO blocks.
// The LED output PIOs reuse ADDR_DATA from here.
package key_edge_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/key_edge_pio_if.sv
// Avalon-MM slave port of the PIO, including its level interrupt line.
interface key_edge_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/key_edge_pio_sync_edge.sv
// Synchroniser chain for the asynchronous input lines plus a one-cycle
// previous sample, producing a per-bit pulse for the selected edge type.
module pio_sync_edge
    import key_edge_pio_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               EDGE_TYPE   = EDGE_FALL,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] SYNC_RESET  = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RESET;
            r_prev <= SYNC_RESET;
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = o_sync & ~r_prev;
    assign w_fall = ~o_sync & r_prev;

    always_comb begin
        o_edge = w_rise | w_fall;
        case (EDGE_TYPE)
            EDGE_RISE: o_edge = w_rise;
            EDGE_FALL: o_edge = w_fall;
            default:   o_edge = w_rise | w_fall;
        endcase
    end

endmodule

// File: rtl/key_edge_pio.sv
// Input PIO for DE2 keys/switches: synchronised data read-back, sticky
// edge-capture register with write-1-to-clear, and a maskable level irq.
module key_edge_pio
    import key_edge_pio_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               EDGE_TYPE   = EDGE_FALL,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] SYNC_RESET  = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    key_edge_pio_if.slave    bus
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [31:0]      r_readdata;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES),
        .SYNC_RESET  (SYNC_RESET)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_in    (in_port),
        .o_sync  (w_sync),
        .o_edge  (w_edge)
    );

    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_clr = (w_wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_sync;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_capture;
            default:   w_rd_mux = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a same-cycle clear never drops one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask     <= '0;
            r_capture  <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr && bus.address == ADDR_MASK) r_mask <= bus.writedata[WIDTH-1:0];
            r_capture  <= (r_capture & ~w_clr) | w_edge;
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_key_edge_pio.sv
// Directed and randomized bench for key_edge_pio (WIDTH=4, falling edges)
// against a history-based reference of the synchronised input lines.
module tb_key_edge_pio;
    import key_edge_pio_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    int         checks;
    int         errors;

    logic [3:0] m_hist[$];
    logic [3:0] m_mask;
    logic [3:0] m_cap;
    logic [3:0] cur_in;

    key_edge_pio_if bus();

    key_edge_pio #(
        .WIDTH       (4),
        .EDGE_TYPE   (EDGE_FALL),
        .SYNC_STAGES (2),
        .SYNC_RESET  (4'hF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = {4'hF, 4'hF, 4'hF};
        m_mask = '0;
        m_cap  = '0;
    endtask

    // One clock: the line value seen on the bus side is the input sampled two
    // edges earlier; a capture bit sets when that value goes 1 -> 0.
    task automatic tick(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [3:0] inp);
        logic [3:0]  seen_now, seen_before, fell, clr;
        logic [31:0] exp_rd;
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        in_port        = inp;
        seen_now    = m_hist[$-1];
        seen_before = m_hist[$-2];
        exp_rd = 32'h0;
        if (a == 2'd0) exp_rd = {28'h0, seen_now};
        if (a == 2'd2) exp_rd = {28'h0, m_mask};
        if (a == 2'd3) exp_rd = {28'h0, m_cap};
        fell = seen_before & ~seen_now;
        clr  = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'h0;
        m_cap = (m_cap & ~clr) | fell;
        if (cs && !wn && a == 2'd2) m_mask = wd[3:0];
        m_hist.push_back(inp);
        @(posedge clk);
        #1;
        chk("readdata", bus.readdata, exp_rd);
        chk("irq", {31'h0, bus.irq}, {31'h0, |(m_cap & m_mask)});
    endtask

    task automatic rd(input logic [1:0] a);
        tick(a, 1'b0, 1'b1, 32'h0, cur_in);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tick(a, 1'b1, 1'b0, d, cur_in);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        cur_in = 4'hF; in_port = 4'hF;
        reset_n = 1'b1;
        model_reset();
        #12;

        // 1: reset and first data read
        do_reset();
        rd(ADDR_DATA);
        chk("t1_data", bus.readdata, 32'h0000000F);
        rd(ADDR_EDGE);
        chk("t1_nocap", bus.readdata, 32'h0);

        // 2: falling edge latency, release does not capture
        wr(ADDR_MASK, 32'h1);
        cur_in = 4'hE;
        rd(ADDR_EDGE);
        rd(ADDR_EDGE);
        chk("t2_irq_edge2", {31'h0, bus.irq}, 32'h0);
        rd(ADDR_EDGE);
        chk("t2_irq_edge3", {31'h0, bus.irq}, 32'h1);
        rd(ADDR_EDGE);
        chk("t2_cap", bus.readdata, 32'h1);
        cur_in = 4'hF;
        repeat (4) rd(ADDR_EDGE);
        chk("t2_no_rise", bus.readdata, 32'h1);

        // 3: write-1-to-clear
        cur_in = 4'h5;
        repeat (3) rd(ADDR_EDGE);
        rd(ADDR_EDGE);
        chk("t3_cap_b", bus.readdata, 32'hB);
        wr(ADDR_EDGE, 32'h2);
        rd(ADDR_EDGE);
        chk("t3_cap_9", bus.readdata, 32'h9);
        chk("t3_irq_hold", {31'h0, bus.irq}, 32'h1);
        wr(ADDR_EDGE, 32'h9);
        chk("t3_irq_clr", {31'h0, bus.irq}, 32'h0);
        cur_in = 4'hF;
        repeat (3) rd(ADDR_DATA);

        // 4: clear collides with a detected edge
        cur_in = 4'hE;
        rd(ADDR_EDGE);
        rd(ADDR_EDGE);
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE);
        chk("t4_collide", bus.readdata, 32'h1);
        cur_in = 4'hF;
        repeat (3) rd(ADDR_DATA);

        // 5: mask gating
        wr(ADDR_EDGE, 32'hF);
        wr(ADDR_MASK, 32'h0);
        cur_in = 4'hB;
        repeat (4) rd(ADDR_EDGE);
        chk("t5_cap4", bus.readdata, 32'h4);
        chk("t5_irq_masked", {31'h0, bus.irq}, 32'h0);
        wr(ADDR_MASK, 32'h4);
        chk("t5_irq_unmask", {31'h0, bus.irq}, 32'h1);
        wr(ADDR_MASK, 32'h0);
        chk("t5_irq_remask", {31'h0, bus.irq}, 32'h0);
        rd(ADDR_EDGE);
        chk("t5_cap_kept", bus.readdata, 32'h4);

        // 6: read map and latency
        rd(ADDR_RSVD);
        chk("t6_rsvd", bus.readdata, 32'h0);
        wr(ADDR_MASK, 32'hFFFFFFFF);
        rd(ADDR_MASK);
        chk("t6_mask_rd", bus.readdata, 32'h0000000F);
        wr(ADDR_DATA, 32'h0);
        wr(ADDR_RSVD, 32'h0);
        rd(ADDR_MASK);
        chk("t6_ignored_wr", bus.readdata, 32'h0000000F);

        // randomized traffic, including deselected write strobes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) cur_in = 4'($urandom);
            tick(2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom, cur_in);
        end

        // mid-operation reset drops pending captures
        cur_in = 4'h0;
        repeat (4) rd(ADDR_EDGE);
        do_reset();
        cur_in = 4'hF;
        rd(ADDR_EDGE);
        chk("rst2_cap", bus.readdata, 32'h0);
        rd(ADDR_MASK);
        chk("rst2_mask", bus.readdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
